// File: rtl/pipeline_unwind.sv
// pipeline_unwind: elastic decoder that undoes the Stage/Pipeline encoder.
// A head stage captures in >> 1 and the parity bit. DEPTH decrement stages
// follow it, each with its own valid bit. Backpressure ripples back through a
// per-stage advance signal, so bubbles collapse and a full pipe stalls as one.

// One pipeline slot: holds the valid bit, the data byte and the err bit.
// DEC selects whether the incoming byte is decremented on load.
module pipeline_unwind_stage #(
    parameter logic DEC = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    input  logic       vin,
    input  logic [7:0] din,
    input  logic       ein,
    output logic       v,
    output logic [7:0] d,
    output logic       e
);

    // Load on advance. Data and err change only behind a valid word, so a
    // bubble passing through leaves the last decoded value on the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= 8'h00;
            e <= 1'b0;
        end else if (adv) begin
            v <= vin;
            if (vin) begin
                d <= DEC ? (din - 8'd1) : din;
                e <= ein;
            end
        end
    end

endmodule

module pipeline_unwind #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out,
    output logic       err,
    output logic [7:0] err_count
);

    logic [DEPTH:0]      vld_pipe;
    logic [DEPTH:0][7:0] dat;
    logic [DEPTH:0]      errb;
    logic [DEPTH:0]      adv;
    logic                accept;

    // Stage k may move when the consumer pops, or when it or any stage
    // downstream of it holds a bubble. The closed form avoids a
    // bit-to-bit combinational chain inside one vector.
    for (genvar k = 0; k <= DEPTH; k++) begin : g_adv
        assign adv[k] = out_ready || !(&vld_pipe[DEPTH:k]);
    end

    assign in_ready  = adv[0] && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_pipe[DEPTH];
    assign out       = dat[DEPTH];
    assign err       = errb[DEPTH];

    // Stage 0 takes the halved input and the parity bit. Stages 1..DEPTH
    // each subtract one, which adds up to the encoder's +DEPTH in reverse.
    for (genvar k = 0; k <= DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            pipeline_unwind_stage #(.DEC(1'b0)) u_stage (
                .clk (clk),
                .rst (rst),
                .adv (adv[0]),
                .vin (accept),
                .din ({1'b0, in[7:1]}),
                .ein (in[0]),
                .v   (vld_pipe[0]),
                .d   (dat[0]),
                .e   (errb[0])
            );
        end else begin : g_dec
            pipeline_unwind_stage #(.DEC(1'b1)) u_stage (
                .clk (clk),
                .rst (rst),
                .adv (adv[k]),
                .vin (vld_pipe[k-1]),
                .din (dat[k-1]),
                .ein (errb[k-1]),
                .v   (vld_pipe[k]),
                .d   (dat[k]),
                .e   (errb[k])
            );
        end
    end

    // Count odd words as they are accepted. The count saturates at 255 and
    // does not wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'h00;
        end else if (accept && in[0] && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule
